// File: rtl/cmd_issuer_pkg.sv
// Shared types for the CPU command issuer: FSM states, command word type and the NOP opcode.
package cmd_issuer_pkg;

  typedef logic [6:0] cmd_t;

  localparam cmd_t NOP = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    CAPTURE
  } state_e;

endpackage

// File: rtl/cmd_issuer_fifo.sv
// cmd_fifo: in-order command queue with power-of-two depth and an occupancy count.
module cmd_fifo #(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: queues commands and feeds them one at a time to a CPU, returning its results.
// Optional issue timeout enabled by defining CMD_ISSUER_TIMEOUT_EN.
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk1,
  input  logic                     reset1,
  input  logic                     push_valid,
  input  cmd_t                     push_cmd,
  output logic                     push_ready,
  output cmd_t                     cmd_out,
  input  logic                     cpu_rdy,
  input  logic [2*WIDTH-1:0]       cpu_result,
  input  logic                     cpu_zero,
  input  logic                     cpu_error,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_data,
  output logic                     res_zero,
  output logic                     res_error,
  output cmd_t                     res_cmd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  state_e state, state_next;
  cmd_t   head;
  cmd_t   cur_cmd;
  logic   full, empty;
  logic   pop, start, accept, capture, timeout_hit;

  assign push_ready = !full;

  cmd_fifo #(.WIDTH(7), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk1),
    .rst_n     (reset1),
    .push      (push_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != ISSUE || timeout_hit) to_cnt <= '0;
      else if (cpu_rdy)                  to_cnt <= to_cnt + TO_W'(1);
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: every comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (!empty && cpu_rdy) begin
        start      = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (!cpu_rdy) begin
          accept     = 1'b1;
          pop        = 1'b1;
          state_next = WAIT_DONE;
        end
`ifdef CMD_ISSUER_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          pop         = 1'b1;
          state_next  = IDLE;
        end
`endif
      end
      WAIT_DONE: if (cpu_rdy) state_next = CAPTURE;
      CAPTURE: if (!res_valid) begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) state <= IDLE;
    else         state <= state_next;
  end

  // The accepted command is parked in cur_cmd so res_cmd stays stable while a result is pending.
  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      cmd_out   <= NOP;
      cur_cmd   <= NOP;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_error <= 1'b0;
      res_cmd   <= NOP;
    end else begin
      if (start)                      cmd_out <= head;
      else if (accept || timeout_hit) cmd_out <= NOP;
      if (accept) cur_cmd <= cmd_out;
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= cpu_result;
        res_zero  <= cpu_zero;
        res_error <= cpu_error;
        res_cmd   <= cur_cmd;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Scoreboard bench for cmd_issuer: directed commands, CPU handshake model, result monitor.
// Define CMD_ISSUER_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2*WIDTH-1:0] data;
    logic               zero;
    logic               err;
    cmd_t               cmd;
  } exp_t;

  logic               clk1 = 1'b0;
  logic               reset1;
  logic               push_valid;
  cmd_t               push_cmd;
  logic               push_ready;
  cmd_t               cmd_out;
  logic               cpu_rdy;
  logic [2*WIDTH-1:0] cpu_result;
  logic               cpu_zero;
  logic               cpu_error;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic               res_zero;
  logic               res_error;
  cmd_t               res_cmd;
  logic [$clog2(DEPTH):0] fifo_count;
  logic               timeout_err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk1        (clk1),
    .reset1      (reset1),
    .push_valid  (push_valid),
    .push_cmd    (push_cmd),
    .push_ready  (push_ready),
    .cmd_out     (cmd_out),
    .cpu_rdy     (cpu_rdy),
    .cpu_result  (cpu_result),
    .cpu_zero    (cpu_zero),
    .cpu_error   (cpu_error),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_error   (res_error),
    .res_cmd     (res_cmd),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake is compared against the oldest expected entry.
  always @(negedge clk1) begin
    if (reset1 && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got cmd %0h data %0h, expected none", res_cmd, res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_zero", res_zero, e.zero);
        check("res_error", res_error, e.err);
        check("res_cmd", res_cmd, e.cmd);
      end
    end
  end

  task automatic push(input cmd_t c);
    push_valid = 1'b1;
    push_cmd   = c;
    @(posedge clk1);
    #1 push_valid = 1'b0;
  endtask

  task automatic wait_cmd(input cmd_t exp);
    int k = 0;
    @(negedge clk1);
    while (cmd_out == NOP && k < 50) begin
      @(negedge clk1);
      k++;
    end
    check("issue_order", cmd_out, exp);
  endtask

  task automatic wait_res();
    int k = 0;
    @(negedge clk1);
    while (!res_valid && k < 50) begin
      @(negedge clk1);
      k++;
    end
    check("res_valid_seen", res_valid, 1'b1);
  endtask

  // CPU model: take the command one cycle after it appears, finish three cycles later.
  task automatic cpu_serve(input cmd_t exp, input logic [15:0] result, input logic z, input logic e);
    exp_t x;
    wait_cmd(exp);
    x.data = result; x.zero = z; x.err = e; x.cmd = exp;
    sb.push_back(x);
    @(posedge clk1);
    #1 cpu_rdy = 1'b0;
    @(posedge clk1);
    @(posedge clk1);
    #1 check("cmd_out_nop_busy", cmd_out, NOP);
    @(posedge clk1);
    #1;
    cpu_result = result;
    cpu_zero   = z;
    cpu_error  = e;
    cpu_rdy    = 1'b1;
  endtask

  initial begin
    reset1 = 1'b0; push_valid = 1'b0; push_cmd = NOP; cpu_rdy = 1'b1;
    cpu_result = '0; cpu_zero = 1'b0; cpu_error = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk1);
    check("rst_cmd_out", cmd_out, NOP);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_push_ready", push_ready, 1);
    check("rst_timeout_err", timeout_err, 0);
    reset1 = 1'b1;
    @(posedge clk1); #1;

    // Single command.
    push(7'h15);
    cpu_serve(7'h15, 16'h00A0, 1'b0, 1'b0);
    wait_res();
    check("single_res_data", res_data, 16'h00A0);
    check("single_res_cmd", res_cmd, 7'h15);
    check("single_cmd_out_nop", cmd_out, NOP);
    cpu_rdy = 1'b0;
    repeat (3) @(posedge clk1); #1;

    // Full FIFO: the fifth push must be dropped.
    for (int i = 0; i < 5; i++) push(cmd_t'(7'h21 + i));
    check("full_count", fifo_count, 4);
    check("full_push_ready", push_ready, 0);
    cpu_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cpu_serve(cmd_t'(7'h21 + i), 16'h0100 + 16'(i), 1'b0, 1'b0);
    wait_res();
    repeat (8) @(posedge clk1); #1;
    check("full_drained_count", fifo_count, 0);
    check("full_no_fifth", cmd_out, NOP);

    // Flags pass through.
    push(7'h33);
    cpu_serve(7'h33, 16'h0000, 1'b1, 1'b1);
    wait_res();
    check("flag_zero", res_zero, 1);
    check("flag_error", res_error, 1);
    repeat (2) @(posedge clk1); #1;

    // Backpressure across two commands.
    res_ready = 1'b0;
    push(7'h41);
    push(7'h42);
    cpu_serve(7'h41, 16'h1111, 1'b0, 1'b0);
    wait_res();
    cpu_serve(7'h42, 16'h2222, 1'b0, 1'b1);
    repeat (6) @(posedge clk1); #1;
    check("bp_hold_data", res_data, 16'h1111);
    check("bp_hold_cmd", res_cmd, 7'h41);
    check("bp_state_capture", dut.state, CAPTURE);
    res_ready = 1'b1;
    @(posedge clk1); #1 res_ready = 1'b0;
    wait_res();
    check("bp_second_data", res_data, 16'h2222);
    check("bp_second_cmd", res_cmd, 7'h42);
    res_ready = 1'b1;
    repeat (3) @(posedge clk1); #1;

    // Reset while waiting for the CPU with two commands still queued.
    push(7'h51); push(7'h52); push(7'h53);
    wait_cmd(7'h51);
    @(posedge clk1); #1 cpu_rdy = 1'b0;
    repeat (2) @(posedge clk1); #1;
    check("mid_count_before", fifo_count, 2);
    check("mid_state_wait", dut.state, WAIT_DONE);
    reset1 = 1'b0;
    #1;
    check("mid_rst_cmd_out", cmd_out, NOP);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_res_cmd", res_cmd, NOP);
    check("mid_rst_flags", {res_zero, res_error, timeout_err}, 3'b000);
    @(negedge clk1);
    reset1  = 1'b1;
    cpu_rdy = 1'b1;
    repeat (6) @(posedge clk1); #1;
    check("mid_after_count", fifo_count, 0);
    check("mid_after_res_valid", res_valid, 0);
    check("mid_after_cmd_out", cmd_out, NOP);

`ifdef CMD_ISSUER_TIMEOUT_EN
    // Timeout: CPU never drops cpu_rdy during ISSUE.
    push(7'h61);
    wait_cmd(7'h61);
    check("to_count_before", fifo_count, 1);
    repeat (15) @(posedge clk1); #1;
    check("to_not_yet", timeout_err, 0);
    @(posedge clk1); #1;
    check("to_err_set", timeout_err, 1);
    check("to_count_after", fifo_count, 0);
    check("to_cmd_out_nop", cmd_out, NOP);
    repeat (6) @(posedge clk1); #1;
    check("to_no_result", res_valid, 0);
    check("to_err_sticky", timeout_err, 1);
`else
    check("to_disabled", timeout_err, 0);
`endif

    repeat (4) @(posedge clk1); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
